// File: rtl/spi_xfer_sched.sv
// Round-robin scheduler that arbitrates SPI transfer requests and sequences
// one shift-engine transaction (load, start, busy, slave-select hold) per grant.
`timescale 1ns/1ps
module spi_xfer_sched #(
    parameter int NREQ   = 2,
    parameter int LEN_W  = 5,
    parameter int SS_NB  = 8,
    parameter int GO_TMO = 15
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*32-1:0]    req_data,
    input  logic [NREQ*LEN_W-1:0] req_len,
    input  logic [NREQ-1:0]       req_lsb,
    input  logic [NREQ*SS_NB-1:0] req_ss,
    output logic [NREQ-1:0]       gnt,
    output logic                  done,
    output logic                  err,
    output logic [1:0]            done_id,
    output logic [31:0]           rdata,
    output logic                  go,
    output logic [3:0]            latch,
    output logic [3:0]            byte_sel,
    output logic [LEN_W-1:0]      len,
    output logic                  lsb,
    output logic [31:0]           p_in,
    input  logic                  tip,
    input  logic [31:0]           p_out,
    output logic [SS_NB-1:0]      ss_n
);
    localparam int unsigned NREQ_U = NREQ;
    localparam int CW = (GO_TMO > 1) ? $clog2(GO_TMO) : 1;

    typedef enum logic [2:0] {IDLE, LOAD, START, BUSY, HOLD} state_t;

    state_t           state, state_d;
    logic [1:0]       ptr_q;
    logic [SS_NB-1:0] ss_q;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [3:0]       req4;
    logic [1:0]       win;
    logic             found;
    logic [31:0]      sel_data;
    logic [LEN_W-1:0] sel_len;
    logic             sel_lsb;
    logic [SS_NB-1:0] sel_ss;
    logic [NREQ-1:0]  gnt_d;
    logic             grab, cap, done_d, err_d;

    assign req4 = 4'(req);

    // Search starts one above the last winner, wrapping within NREQ.
    always_comb begin
        int unsigned c;
        c     = 0;
        found = 1'b0;
        win   = '0;
        for (int unsigned i = 0; i < NREQ_U; i++) begin
            c = 32'(ptr_q) + 32'd1 + i;
            if (c >= NREQ_U) c = c - NREQ_U;
            if (!found && req4[c[1:0]]) begin
                found = 1'b1;
                win   = c[1:0];
            end
        end
    end

    always_comb begin
        sel_data = '0;
        sel_len  = '0;
        sel_lsb  = 1'b0;
        sel_ss   = '0;
        for (int unsigned j = 0; j < NREQ_U; j++) begin
            if (win == j[1:0]) begin
                sel_data = req_data[j*32 +: 32];
                sel_len  = req_len[j*LEN_W +: LEN_W];
                sel_lsb  = req_lsb[j];
                sel_ss   = req_ss[j*SS_NB +: SS_NB];
            end
        end
    end

    always_comb begin
        state_d = state;
        cnt_d   = cnt_q;
        gnt_d   = '0;
        grab    = 1'b0;
        cap     = 1'b0;
        done_d  = 1'b0;
        err_d   = 1'b0;
        case (state)
            IDLE: begin
                if (found && !tip) begin
                    state_d = LOAD;
                    gnt_d   = NREQ'(4'b0001 << win);
                    grab    = 1'b1;
                end
            end
            LOAD: begin
                state_d = START;
                cnt_d   = '0;
            end
            START: begin
                if (tip) begin
                    state_d = BUSY;
                end else if (cnt_q == CW'(GO_TMO - 1)) begin
                    state_d = HOLD;
                    done_d  = 1'b1;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            BUSY: begin
                if (!tip) begin
                    state_d = HOLD;
                    done_d  = 1'b1;
                    cap     = 1'b1;
                end
            end
            HOLD:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            ptr_q   <= 2'(NREQ - 1);
            ss_q    <= '0;
            cnt_q   <= '0;
            gnt     <= '0;
            done    <= 1'b0;
            err     <= 1'b0;
            done_id <= '0;
            rdata   <= '0;
            len     <= '0;
            lsb     <= 1'b0;
            p_in    <= '0;
        end else begin
            state <= state_d;
            cnt_q <= cnt_d;
            gnt   <= gnt_d;
            done  <= done_d;
            err   <= err_d;
            if (grab) begin
                ptr_q <= win;
                p_in  <= sel_data;
                len   <= sel_len;
                lsb   <= sel_lsb;
                ss_q  <= sel_ss;
            end
            if (done_d) done_id <= ptr_q;
            if (cap) rdata <= p_out;
        end
    end

    // Decoded from state so reset releases go and ss_n without a clock edge.
    assign go       = (state == START) && !tip;
    assign latch    = (state == LOAD) ? 4'b0001 : 4'b0000;
    assign byte_sel = (state == LOAD) ? 4'hF : 4'h0;
    assign ss_n     = (state == IDLE) ? '1 : ~ss_q;

endmodule

// File: tb/tb_spi_xfer_sched.sv
// Self-checking bench for spi_xfer_sched: vector table of transfers, an engine
// model, and a scoreboard matching completions against granted transfers.
`timescale 1ns/1ps
module tb_spi_xfer_sched;
    localparam int NREQ   = 2;
    localparam int LEN_W  = 5;
    localparam int SS_NB  = 8;
    localparam int GO_TMO = 15;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [NREQ-1:0]       req;
    logic [NREQ*32-1:0]    req_data;
    logic [NREQ*LEN_W-1:0] req_len;
    logic [NREQ-1:0]       req_lsb;
    logic [NREQ*SS_NB-1:0] req_ss;
    logic [NREQ-1:0]       gnt;
    logic                  done, err;
    logic [1:0]            done_id;
    logic [31:0]           rdata;
    logic                  go;
    logic [3:0]            latch, byte_sel;
    logic [LEN_W-1:0]      len;
    logic                  lsb;
    logic [31:0]           p_in;
    logic                  tip;
    logic [31:0]           p_out;
    logic [SS_NB-1:0]      ss_n;

    spi_xfer_sched #(.NREQ(NREQ), .LEN_W(LEN_W), .SS_NB(SS_NB), .GO_TMO(GO_TMO)) dut (
        .clk(clk), .rst(rst), .req(req), .req_data(req_data), .req_len(req_len),
        .req_lsb(req_lsb), .req_ss(req_ss), .gnt(gnt), .done(done), .err(err),
        .done_id(done_id), .rdata(rdata), .go(go), .latch(latch), .byte_sel(byte_sel),
        .len(len), .lsb(lsb), .p_in(p_in), .tip(tip), .p_out(p_out), .ss_n(ss_n)
    );

    always #5 clk = ~clk;

    // Engine: tip rises two cycles after go, stays high 16 cycles.
    logic        eng_en;
    logic [31:0] eng_pout;
    int unsigned eng_k;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            eng_k <= 0;
            tip   <= 1'b0;
        end else if (eng_k == 0) begin
            tip <= 1'b0;
            if (go && eng_en) eng_k <= 1;
        end else if (eng_k <= 16) begin
            eng_k <= eng_k + 1;
            tip   <= 1'b1;
        end else begin
            eng_k <= 0;
            tip   <= 1'b0;
        end
    end
    assign p_out = eng_pout;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    typedef struct {
        logic [1:0]  id;
        logic [31:0] rdata;
        logic        err;
    } exp_t;
    exp_t        sbq[$];
    exp_t        me;
    logic [31:0] last_rdata;

    always @(negedge clk) begin
        if (!rst) begin
            chk("latch_in_load", 64'(latch), 64'((gnt != '0) ? 4'b0001 : 4'b0000));
            chk("byte_sel_in_load", 64'(byte_sel), 64'((gnt != '0) ? 4'hF : 4'h0));
            if (done) begin
                if (sbq.size() == 0) begin
                    chk("done_unexpected", 64'(done), 64'd0);
                end else begin
                    me = sbq.pop_front();
                    chk("done_id", 64'(done_id), 64'(me.id));
                    chk("rdata", 64'(rdata), 64'(me.rdata));
                    chk("err", 64'(err), 64'(me.err));
                end
            end else if (err) begin
                chk("err_without_done", 64'(err), 64'd0);
            end
        end
    end

    typedef struct {
        logic [1:0]  req;
        logic        hold;
        logic [31:0] d;
        logic [4:0]  ln;
        logic        ls;
        logic [7:0]  ss;
        logic        eng;
        logic [31:0] po;
        logic [1:0]  id;
        logic        glitch;
    } vec_t;
    vec_t vecs[9];

    task automatic run_vec(input vec_t v, input int idx);
        bit          seen, done_seen;
        int unsigned go_cycles, tip_cycles, gl;
        logic [1:0]  eg;
        logic [7:0]  ssn_exp;
        exp_t        e;
        for (int s = 0; s < NREQ; s++) begin
            if (2'(s) == v.id) begin
                req_data[s*32 +: 32]       = v.d;
                req_len[s*LEN_W +: LEN_W]  = v.ln;
                req_lsb[s]                 = v.ls;
                req_ss[s*SS_NB +: SS_NB]   = v.ss;
            end else begin
                req_data[s*32 +: 32]       = ~v.d;
                req_len[s*LEN_W +: LEN_W]  = ~v.ln;
                req_lsb[s]                 = ~v.ls;
                req_ss[s*SS_NB +: SS_NB]   = {v.ss[0], v.ss[7:1]};
            end
        end
        eng_en   = v.eng;
        eng_pout = v.po;
        req      = v.req;
        seen     = 1'b0;
        for (int n = 0; n < 40 && !seen; n++) begin
            @(negedge clk);
            seen = (gnt != '0);
        end
        chk($sformatf("v%0d_gnt_seen", idx), 64'(seen), 64'd1);
        if (!seen) begin
            req = '0;
            return;
        end
        eg      = 2'b01 << v.id;
        ssn_exp = ~v.ss;
        chk($sformatf("v%0d_gnt", idx), 64'(gnt), 64'(eg));
        chk($sformatf("v%0d_load_p_in", idx), 64'(p_in), 64'(v.d));
        chk($sformatf("v%0d_load_len", idx), 64'(len), 64'(v.ln));
        chk($sformatf("v%0d_load_lsb", idx), 64'(lsb), 64'(v.ls));
        chk($sformatf("v%0d_load_ss_n", idx), 64'(ss_n), 64'(ssn_exp));
        chk($sformatf("v%0d_load_go", idx), 64'(go), 64'd0);
        if (!v.hold) req = '0;
        e.id       = v.id;
        e.err      = !v.eng;
        e.rdata    = v.eng ? v.po : last_rdata;
        last_rdata = e.rdata;
        sbq.push_back(e);

        done_seen  = 1'b0;
        go_cycles  = 0;
        tip_cycles = 0;
        gl         = 0;
        for (int n = 0; n < 80 && !done_seen; n++) begin
            @(negedge clk);
            if (go) go_cycles++;
            if (tip) tip_cycles++;
            done_seen = done;
            chk($sformatf("v%0d_len_stable", idx), 64'(len), 64'(v.ln));
            chk($sformatf("v%0d_lsb_stable", idx), 64'(lsb), 64'(v.ls));
            chk($sformatf("v%0d_p_in_stable", idx), 64'(p_in), 64'(v.d));
            chk($sformatf("v%0d_ss_n_held", idx), 64'(ss_n), 64'(ssn_exp));
            chk($sformatf("v%0d_no_gnt", idx), 64'(gnt), 64'd0);
            if (gl == 1) begin
                req[1] = 1'b0;
                gl     = 2;
            end else if (v.glitch && gl == 0 && tip_cycles == 3) begin
                req[1] = 1'b1;
                gl     = 1;
            end
        end
        chk($sformatf("v%0d_done_seen", idx), 64'(done_seen), 64'd1);
        chk($sformatf("v%0d_go_cycles", idx), 64'(go_cycles), 64'(v.eng ? 2 : GO_TMO));
        @(negedge clk);
        chk($sformatf("v%0d_ss_n_released", idx), 64'(ss_n), 64'hFF);
        chk($sformatf("v%0d_go_idle", idx), 64'(go), 64'd0);
        if (v.glitch) begin
            repeat (5) begin
                @(negedge clk);
                chk($sformatf("v%0d_no_late_gnt", idx), 64'(gnt), 64'd0);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        bit seen;
        vecs[0] = '{2'b01, 1'b0, 32'h000000A5, 5'd8,  1'b0, 8'h01, 1'b1, 32'h0000003C, 2'd0, 1'b0};
        vecs[1] = '{2'b10, 1'b0, 32'h12345678, 5'd0,  1'b1, 8'h80, 1'b1, 32'h87654321, 2'd1, 1'b0};
        vecs[2] = '{2'b11, 1'b1, 32'hA1A1A1A1, 5'd16, 1'b0, 8'h02, 1'b1, 32'h0000B0B0, 2'd0, 1'b0};
        vecs[3] = '{2'b11, 1'b1, 32'hB2B2B2B2, 5'd24, 1'b1, 8'h04, 1'b1, 32'h0000C1C1, 2'd1, 1'b0};
        vecs[4] = '{2'b11, 1'b1, 32'hC3C3C3C3, 5'd7,  1'b0, 8'h08, 1'b1, 32'h0000D2D2, 2'd0, 1'b0};
        vecs[5] = '{2'b11, 1'b0, 32'hD4D4D4D4, 5'd12, 1'b1, 8'h10, 1'b1, 32'h0000E3E3, 2'd1, 1'b0};
        vecs[6] = '{2'b01, 1'b0, 32'h0F0F0F0F, 5'd3,  1'b0, 8'h03, 1'b0, 32'hFFFFFFFF, 2'd0, 1'b0};
        vecs[7] = '{2'b10, 1'b0, 32'hDEADBEEF, 5'd31, 1'b0, 8'h40, 1'b1, 32'hCAFEF00D, 2'd1, 1'b0};
        vecs[8] = '{2'b01, 1'b0, 32'h00C0FFEE, 5'd1,  1'b1, 8'h20, 1'b1, 32'h13579BDF, 2'd0, 1'b1};

        rst        = 1'b1;
        req        = 2'b11;
        req_data   = '1;
        req_len    = '1;
        req_lsb    = '1;
        req_ss     = '1;
        eng_en     = 1'b0;
        eng_pout   = '0;
        last_rdata = '0;
        repeat (2) @(negedge clk);
        chk("rst_gnt", 64'(gnt), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_err", 64'(err), 64'd0);
        chk("rst_done_id", 64'(done_id), 64'd0);
        chk("rst_rdata", 64'(rdata), 64'd0);
        chk("rst_go", 64'(go), 64'd0);
        chk("rst_latch", 64'(latch), 64'd0);
        chk("rst_byte_sel", 64'(byte_sel), 64'd0);
        chk("rst_len", 64'(len), 64'd0);
        chk("rst_lsb", 64'(lsb), 64'd0);
        chk("rst_p_in", 64'(p_in), 64'd0);
        chk("rst_ss_n", 64'(ss_n), 64'hFF);
        req = '0;
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 7; i++) run_vec(vecs[i], i);

        // Reset while the engine is busy, then check a clean restart.
        req_data[31:0] = 32'h11112222;
        req_len[4:0]   = 5'd9;
        req_lsb[0]     = 1'b0;
        req_ss[7:0]    = 8'h04;
        eng_en         = 1'b1;
        eng_pout       = 32'h5555AAAA;
        req            = 2'b01;
        seen           = 1'b0;
        for (int n = 0; n < 40 && !seen; n++) begin
            @(negedge clk);
            seen = (gnt != '0);
        end
        chk("midrst_gnt_seen", 64'(seen), 64'd1);
        req  = '0;
        seen = 1'b0;
        for (int n = 0; n < 40 && !seen; n++) begin
            @(negedge clk);
            seen = tip;
        end
        chk("midrst_tip_seen", 64'(seen), 64'd1);
        repeat (3) @(negedge clk);
        chk("midrst_busy_ss_n", 64'(ss_n), 64'hFB);
        #1 rst = 1'b1;
        #1;
        chk("midrst_go", 64'(go), 64'd0);
        chk("midrst_ss_n", 64'(ss_n), 64'hFF);
        chk("midrst_done", 64'(done), 64'd0);
        repeat (2) @(negedge clk);
        chk("midrst_rdata", 64'(rdata), 64'd0);
        rst        = 1'b0;
        last_rdata = '0;
        repeat (4) begin
            @(negedge clk);
            chk("postrst_no_done", 64'(done), 64'd0);
            chk("postrst_ss_n", 64'(ss_n), 64'hFF);
        end

        for (int i = 7; i < 9; i++) run_vec(vecs[i], i);

        repeat (3) @(negedge clk);
        chk("sb_empty", 64'(sbq.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/spi_xfer_sched.md
SPI_XFER_SCHED -- requirements
Module: spi_xfer_sched

Interface
REQ-001 SHALL have parameter NREQ, default 2, giving the number of requesters (2..4).
REQ-002 SHALL have parameter LEN_W, default 5, giving the character-length field width.
REQ-003 SHALL have parameter SS_NB, default 8, giving the number of slave-select lines.
REQ-004 SHALL have parameter GO_TMO, default 15, giving the maximum cycles from go to tip assertion.
REQ-005 SHALL have port clk, input, 1 bit: system clock.
REQ-006 SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-007 SHALL have port req, input, NREQ bits: per-requester transfer request, level, held until gnt.
REQ-008 SHALL have port req_data, input, NREQ*32 bits: per-requester transmit word.
REQ-009 SHALL have port req_len, input, NREQ*LEN_W bits: per-requester length in bits, where 0 means 2^LEN_W.
REQ-010 SHALL have port req_lsb, input, NREQ bits: per-requester LSB-first flag.
REQ-011 SHALL have port req_ss, input, NREQ*SS_NB bits: per-requester one-hot slave select.
REQ-012 SHALL have port gnt, output, NREQ bits: one-hot, single-cycle pulse when a request is accepted.
REQ-013 SHALL have port done, output, 1 bit: single-cycle completion pulse.
REQ-014 SHALL have port err, output, 1 bit: single-cycle go-timeout pulse, coincident with done.
REQ-015 SHALL have port done_id, output, 2 bits: index of the completed requester.
REQ-016 SHALL have port rdata, output, 32 bits: received word, valid with done.
REQ-017 SHALL have port go, output, 1 bit: shift-engine start.
REQ-018 SHALL have port latch, output, 4 bits: shift-engine parallel-load strobe.
REQ-019 SHALL have port byte_sel, output, 4 bits: shift-engine byte enables.
REQ-020 SHALL have port len, output, LEN_W bits: engine length.
REQ-021 SHALL have port lsb, output, 1 bit: engine bit-order flag.
REQ-022 SHALL have port p_in, output, 32 bits: engine parallel data.
REQ-023 SHALL have port tip, input, 1 bit: engine transfer in progress.
REQ-024 SHALL have port p_out, input, 32 bits: engine parallel out.
REQ-025 SHALL have port ss_n, output, SS_NB bits: active-low slave selects.

Function
REQ-026 SHALL implement FSM states IDLE, LOAD, START, BUSY, HOLD.
REQ-027 IDLE: when any req is high and tip is low, SHALL select a winner round-robin (search begins one index above last winner; after reset, index 0 has highest priority), pulse gnt[winner], register its data/len/lsb/ss, and go to LOAD.
REQ-028 LOAD (1 cycle): SHALL drive latch=4'b0001, byte_sel=4'hF, p_in=registered data, and drive ss_n low on the registered one-hot ss, then go to START.
REQ-029 START: SHALL hold go=1 until tip is sampled high, then go to BUSY with go=0 on the same cycle tip is seen.
REQ-030 START: SHALL count cycles; if tip has not been seen after GO_TMO cycles, SHALL drop go, pulse done and err, and go to HOLD.
REQ-031 BUSY: on the first cycle tip is sampled low, SHALL capture p_out into rdata, pulse done with done_id, and go to HOLD.
REQ-032 HOLD (1 cycle): SHALL keep ss_n asserted, then release ss_n to all-ones and return to IDLE.
REQ-033 gnt SHALL be asserted no earlier than the cycle after IDLE is entered, giving at most one grant per transfer.
REQ-034 len, lsb, and p_in SHALL remain stable from LOAD through BUSY.
REQ-035 latch and byte_sel SHALL be zero outside LOAD.
REQ-036 A request deasserted before grant SHALL be ignored, with no grant and no side effect.
REQ-037 When requests are simultaneous, exactly one SHALL be granted per transfer, and the round-robin pointer SHALL update only on grant.
REQ-038 If req_ss is not one-hot, ss_n SHALL be driven as the bitwise inverse of req_ss as given, with no correction.
REQ-039 Latency from req to go SHALL be 3 cycles: req sampled in IDLE, then LOAD, then START.

Reset
REQ-040 On rst, SHALL enter IDLE immediately.
REQ-041 Reset values SHALL be: gnt=0, done=0, err=0, done_id=0, rdata=0, go=0, latch=0, byte_sel=0, len=0, lsb=0, p_in=0, ss_n=all ones, round-robin pointer set to give index 0 priority.
REQ-042 Reset asserted mid-transfer SHALL release ss_n and drop go within the same cycle, without waiting for tip.

Verification
REQ-043 Bench SHALL cover single transfer: req[0], data 0xA5, len 8, ss 0x01, with an engine model raising tip 2 cycles after go and holding 16 cycles, returning 0x3C -> gnt[0] pulse; ss_n=0xFE from LOAD through HOLD; done with rdata=0x3C and done_id=0; ss_n=0xFF afterwards.
REQ-044 Bench SHALL cover round-robin: req=2'b11 held for 4 transfers -> grant order 0,1,0,1.
REQ-045 Bench SHALL cover go timeout: tip held low with GO_TMO=15 -> go high for 15 cycles, then done and err pulse together, ss_n released after HOLD.
REQ-046 Bench SHALL cover len=0 with lsb=1 -> len output 0 and lsb output 1 stable until done.
REQ-047 Bench SHALL cover reset mid-BUSY -> go=0, ss_n all ones, no done pulse, and a new request granted normally after reset release.
REQ-048 Bench SHALL cover request dropped before grant: req[1] pulsed 1 cycle while the FSM is in BUSY -> no gnt[1].
